pw_seq_lock: RTL and testbench
==============================

# pw_seq_lock

Parametrised switch-sequence combination lock, the next generation of the `pw` password block. It watches N_SW slide switches for rising edges, compares them against a compile-time code sequence of arbitrary length, and reports progress, unlock, failure count and a timed lockout after repeated failures. It sits between the board switch inputs and the display/LED logic; 7-segment rendering is a separate decoder block fed from `state` and `progress`.

## Interface
- `N_SW`, 10: number of switch inputs (2..16).
- `IW`, 4: index width; must satisfy 2^IW ≥ N_SW.
- `CODE_LEN`, 4: number of steps in the code (1..15).
- `CODE`, {4'd3,4'd2,4'd1,4'd0}: packed code; step k expects switch index `CODE[k*IW +: IW]`; step 0 is at the LSBs.
- `MAX_FAIL`, 3: consecutive failures that trigger lockout (1..7).
- `LOCK_CYCLES`, 50_000_000: lockout duration in clocks.
- `TIMEOUT`, 250_000_000: idle clocks allowed between steps in ENTRY.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `sw`  in  N_SW  raw switch levels, asynchronous to `clk`.
- `state`  out  5  one-hot: bit0 IDLE, bit1 ENTRY, bit2 OPEN, bit3 FAIL, bit4 LOCKOUT.
- `progress`  out  4  correct steps accepted so far.
- `fail_cnt`  out  3  consecutive failures.
- `unlocked`  out  1  high only in OPEN.
- `alarm`  out  1  high only in LOCKOUT.

## Operation
- Input path: 2-flop synchroniser per bit, then a history register. `rise = s2 & ~s3`, `fall = ~s2 & s3`, `all_zero = (s2 == 0)`.
- `armed` flag: cleared by reset, set the first cycle `all_zero` is true. All edges are ignored while `armed` = 0, so switches held high through reset never start an entry.
- IDLE: exactly one `rise` bit set -> ENTRY. If it equals CODE step 0, `progress` = 1; otherwise the next state is FAIL. More than one `rise` bit in the same cycle -> FAIL.
- ENTRY: if `rise` is exactly the bit `CODE[progress]`, `progress` increments. When it reaches CODE_LEN -> OPEN.
- ENTRY failure conditions, each -> FAIL:
  - a wrong bit rises;
  - more than one bit rises in the same cycle;
  - any `fall`;
  - the timeout counter reaches TIMEOUT.
- The timeout counter clears on each accepted step.
- OPEN: `fail_cnt` clears on entry. Stays in OPEN until `all_zero`, then -> IDLE with `progress` = 0.
- FAIL: on entry, `fail_cnt` increments (saturates at 7) and `progress` clears.
  - If the new `fail_cnt` ≥ MAX_FAIL -> LOCKOUT next cycle.
  - Otherwise wait for `all_zero` -> IDLE.
- LOCKOUT: all edges are ignored; the lock counter counts LOCK_CYCLES clocks. Then wait for `all_zero` -> IDLE with `fail_cnt` = 0.
- The counters are sized by `$clog2` of their parameter and are cleared on every state change.

## Timing
- Reset values while `rst` is low (asynchronous): `state` = 5'b00001, `progress` = 0, `fail_cnt` = 0, `unlocked` = 0, `alarm` = 0. Synchroniser and history registers are 0, `armed` = 0, all counters are 0.
- All outputs are registered. An `sw` change settling before rising edge E is reflected in `state`/`progress` after edge E+2 (latency 3 clocks).
- FAIL -> LOCKOUT takes exactly 1 clock.
- `alarm` is high for LOCK_CYCLES + 1 clocks minimum, longer if switches remain set.
- Simultaneous events: a correct rise in the same cycle as a `fall` is a failure. A correct rise in the same cycle the timeout expires is accepted, and the timeout is ignored.
- Reset asserted mid-operation returns to the reset state immediately. After release, entry requires all switches to be off first.

## Test plan
- Use LOCK_CYCLES = 20 and TIMEOUT = 30 in the bench; other parameters at default.
- Correct entry: raise sw[0], sw[1], sw[2], sw[3] 20 clocks apart -> `progress` 1, 2, 3, 4; then `unlocked` = 1 and `state` = 5'b00100; set sw = 0 -> IDLE, `fail_cnt` = 0.
- Wrong step: raise sw[0] then sw[2] -> `state` = FAIL, `fail_cnt` = 1, `progress` = 0; set sw = 0 -> IDLE.
- Lockout: three consecutive wrong entries -> third reaches FAIL, then LOCKOUT after 1 clock, `alarm` = 1. Holding sw[0] through the lockout still leaves `alarm` high after 20 clocks. Clearing sw -> IDLE with `fail_cnt` = 0.
- Timeout and fall:
  - Raise sw[0], then idle 30 clocks -> FAIL.
  - Separately, raise sw[0], sw[1], then drop sw[1] -> FAIL.
  - Separately, raise sw[0] and sw[1] in the same cycle -> FAIL.
- Reset mid-entry: raise sw[0], sw[1], pulse `rst` low for 10 clocks -> all outputs reset. With sw[0] and sw[1] still high after release, state stays IDLE until sw = 0; the full correct sequence then unlocks.
- Parameter sweep: N_SW = 4, IW = 2, CODE_LEN = 6, CODE = {2'd0,2'd1,2'd2,2'd3,2'd0,2'd1} -> enter 1, 0, 3, 2, 1, 0 as rises (switches dropped and re-raised after step 4 is a fall -> FAIL). This confirms repeated indices cannot unlock without a fall, i.e. the fall rule is enforced.

Source files
------------

// File: rtl/pw_seq_lock.sv
// Switch-sequence combination lock: synchronised rising-edge entry of a
// parametrised code, with failure counting, entry timeout and timed lockout.
`timescale 1ns/1ps
module pw_seq_lock #(
   parameter int N_SW = 10,
   parameter int IW = 4,
   parameter int CODE_LEN = 4,
   parameter logic [CODE_LEN*IW-1:0] CODE = {4'd3, 4'd2, 4'd1, 4'd0},
   parameter int MAX_FAIL = 3,
   parameter int LOCK_CYCLES = 50_000_000,
   parameter int TIMEOUT = 250_000_000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_SW-1:0] sw,
   output logic [4:0]      state,
   output logic [3:0]      progress,
   output logic [2:0]      fail_cnt,
   output logic            unlocked,
   output logic            alarm
);

   localparam int LW = $clog2(LOCK_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ENTRY = 3'd1,
      S_OPEN  = 3'd2,
      S_FAIL  = 3'd3,
      S_LOCK  = 3'd4
   } st_t;

   st_t st, nst;

   logic [N_SW-1:0] s1, s2, s3;
   logic [N_SW-1:0] rise, fall, ar, af;
   logic [N_SW-1:0] exp_bit;
   logic [IW-1:0]   exp_idx;
   logic [1:0]      vld;
   logic            armed, all_zero, hit;
   logic [3:0]      nprog;
   logic [2:0]      nfc;
   logic [LW-1:0]   lcnt;
   logic [TW-1:0]   tcnt;

   // vld marks when s2 holds a real sample, so the reset zeros cannot arm
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1    <= '0;
         s2    <= '0;
         s3    <= '0;
         vld   <= '0;
         armed <= 1'b0;
      end else begin
         s1  <= sw;
         s2  <= s1;
         s3  <= s2;
         vld <= {vld[0], 1'b1};
         if (vld[1] && all_zero)
            armed <= 1'b1;
      end
   end

   assign rise     = s2 & ~s3;
   assign fall     = ~s2 & s3;
   assign all_zero = ~|s2;
   assign ar       = armed ? rise : '0;
   assign af       = armed ? fall : '0;

   always_comb begin
      exp_idx = '0;
      for (int k = 0; k < CODE_LEN; k++)
         if (progress == 4'(k))
            exp_idx = CODE[k*IW +: IW];
   end

   assign exp_bit = {{(N_SW-1){1'b0}}, 1'b1} << exp_idx;
   assign hit     = (|ar) && (ar == exp_bit);

   always_comb begin
      nst   = st;
      nprog = progress;
      nfc   = fail_cnt;
      unique case (st)
         S_IDLE: begin
            if (|ar) begin
               if (hit) begin
                  nprog = 4'd1;
                  nst = (nprog == 4'(CODE_LEN)) ? S_OPEN : S_ENTRY;
               end else begin
                  nst = S_FAIL;
               end
            end
         end
         S_ENTRY: begin
            // a correct step wins over an expiring timeout, not over a fall
            if (hit && !(|af)) begin
               nprog = progress + 4'd1;
               if (nprog == 4'(CODE_LEN))
                  nst = S_OPEN;
            end else if ((|ar) || (|af) || tcnt == TW'(TIMEOUT)) begin
               nst = S_FAIL;
            end
         end
         S_OPEN: begin
            if (all_zero) begin
               nst   = S_IDLE;
               nprog = '0;
            end
         end
         S_FAIL: begin
            if (fail_cnt >= 3'(MAX_FAIL))
               nst = S_LOCK;
            else if (all_zero)
               nst = S_IDLE;
         end
         S_LOCK: begin
            if (lcnt == LW'(LOCK_CYCLES) && all_zero) begin
               nst = S_IDLE;
               nfc = '0;
            end
         end
         default: nst = S_IDLE;
      endcase
      if (nst == S_FAIL && st != S_FAIL) begin
         nprog = '0;
         nfc   = (fail_cnt == 3'd7) ? 3'd7 : fail_cnt + 3'd1;
      end
      if (nst == S_OPEN && st != S_OPEN)
         nfc = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st       <= S_IDLE;
         state    <= 5'b00001;
         progress <= '0;
         fail_cnt <= '0;
         unlocked <= 1'b0;
         alarm    <= 1'b0;
         tcnt     <= '0;
         lcnt     <= '0;
      end else begin
         st       <= nst;
         state    <= 5'b00001 << nst;
         progress <= nprog;
         fail_cnt <= nfc;
         unlocked <= (nst == S_OPEN);
         alarm    <= (nst == S_LOCK);
         if (nst != st) begin
            tcnt <= '0;
            lcnt <= '0;
         end else begin
            if (st == S_ENTRY)
               tcnt <= hit ? '0 : tcnt + 1'b1;
            if (st == S_LOCK && lcnt != LW'(LOCK_CYCLES))
               lcnt <= lcnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pw_seq_lock.sv
// Scoreboard bench for pw_seq_lock: default 10-switch lock plus a
// 4-switch, 6-step variant with repeated code indices.
`timescale 1ns/1ps
module tb_pw_seq_lock;

   localparam logic [4:0] IDL = 5'b00001;
   localparam logic [4:0] ENT = 5'b00010;
   localparam logic [4:0] OPN = 5'b00100;
   localparam logic [4:0] FL  = 5'b01000;
   localparam logic [4:0] LK  = 5'b10000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [9:0] sw_a = '0;
   logic [3:0] sw_b = '0;
   logic [4:0] st_a, st_b;
   logic [3:0] pg_a, pg_b;
   logic [2:0] fc_a, fc_b;
   logic ul_a, ul_b, al_a, al_b;

   int compared = 0;
   int mism = 0;
   bit mon_en = 1'b0;
   logic [13:0] qa[$];
   logic [13:0] qb[$];
   logic [13:0] prev_a, prev_b, cur_a, cur_b, e_a, e_b;
   int dw_a = 0;
   int lk_dw = 0;

   always #5 clk = ~clk;

   pw_seq_lock #(
      .LOCK_CYCLES(20),
      .TIMEOUT(30)
   ) dut_a (
      .clk(clk), .rst(rst), .sw(sw_a),
      .state(st_a), .progress(pg_a), .fail_cnt(fc_a),
      .unlocked(ul_a), .alarm(al_a)
   );

   pw_seq_lock #(
      .N_SW(4),
      .IW(2),
      .CODE_LEN(6),
      .CODE({2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1}),
      .LOCK_CYCLES(20),
      .TIMEOUT(30)
   ) dut_b (
      .clk(clk), .rst(rst), .sw(sw_b),
      .state(st_b), .progress(pg_b), .fail_cnt(fc_b),
      .unlocked(ul_b), .alarm(al_b)
   );

   function automatic logic [13:0] ex(logic [4:0] s, int p, int f);
      return {s, 4'(p), 3'(f), s == OPN, s == LK};
   endfunction

   // monitor A: pop on every output change, plus dwell checks
   always @(negedge clk) begin
      if (!mon_en) begin
         prev_a = ex(IDL, 0, 0);
         dw_a = 0;
      end else begin
         cur_a = {st_a, pg_a, fc_a, ul_a, al_a};
         if (cur_a != prev_a) begin
            compared++;
            if (qa.size() == 0) begin
               mism++;
               $display("FAIL trace_a: got %h, expected no change", cur_a);
            end else begin
               e_a = qa.pop_front();
               if (cur_a !== e_a) begin
                  mism++;
                  $display("FAIL trace_a: got %h, expected %h", cur_a, e_a);
               end
            end
            if (prev_a[13:9] == FL && cur_a[13:9] == LK) begin
               compared++;
               if (dw_a != 1) begin
                  mism++;
                  $display("FAIL fail_dwell: got %0d, expected 1", dw_a);
               end
            end
            if (prev_a[13:9] == LK) begin
               lk_dw = dw_a;
               compared++;
               if (dw_a < 21) begin
                  mism++;
                  $display("FAIL lock_dwell: got %0d, expected >= 21", dw_a);
               end
            end
            dw_a = 1;
         end else begin
            dw_a++;
         end
         prev_a = cur_a;
      end
   end

   always @(negedge clk) begin
      if (!mon_en) begin
         prev_b = ex(IDL, 0, 0);
      end else begin
         cur_b = {st_b, pg_b, fc_b, ul_b, al_b};
         if (cur_b != prev_b) begin
            compared++;
            if (qb.size() == 0) begin
               mism++;
               $display("FAIL trace_b: got %h, expected no change", cur_b);
            end else begin
               e_b = qb.pop_front();
               if (cur_b !== e_b) begin
                  mism++;
                  $display("FAIL trace_b: got %h, expected %h", cur_b, e_b);
               end
            end
         end
         prev_b = cur_b;
      end
   end

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(string nm, int act, int exp);
      compared++;
      if (act != exp) begin
         mism++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic pa(logic [4:0] s, int p, int f);
      qa.push_back(ex(s, p, f));
   endtask

   task automatic pb(logic [4:0] s, int p, int f);
      qb.push_back(ex(s, p, f));
   endtask

   task automatic drain(string nm);
      int n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
         cyc(1);
         n++;
      end
      compared++;
      if (qa.size() != 0 || qb.size() != 0) begin
         mism++;
         $display("FAIL %s: got %0d/%0d pending, expected 0", nm,
                  qa.size(), qb.size());
         qa.delete();
         qb.delete();
      end
   endtask

   task automatic correct_entry(int fc);
      for (int i = 0; i < 4; i++) begin
         if (i < 3) pa(ENT, i + 1, fc);
         else pa(OPN, 4, 0);
         sw_a[i] = 1'b1;
         cyc(20);
      end
      pa(IDL, 0, 0);
      sw_a = '0;
      cyc(10);
      drain("correct_entry");
   endtask

   task automatic wrong_idle(int fc);
      pa(FL, 0, fc);
      sw_a[5] = 1'b1;
      cyc(5);
      pa(IDL, 0, fc);
      sw_a = '0;
      cyc(6);
      drain("wrong_idle");
   endtask

   initial begin
      cyc(1);
      rst = 1'b0;
      cyc(5);
      chk("rst_state", st_a, 1);
      chk("rst_progress", pg_a, 0);
      chk("rst_fail_cnt", fc_a, 0);
      chk("rst_unlocked", ul_a, 0);
      chk("rst_alarm", al_a, 0);
      chk("rst_state_b", st_b, 1);
      mon_en = 1'b1;
      rst = 1'b1;
      cyc(10);

      correct_entry(0);

      // wrong second step
      pa(ENT, 1, 0);
      sw_a[0] = 1'b1;
      cyc(5);
      pa(FL, 0, 1);
      sw_a[2] = 1'b1;
      cyc(5);
      pa(IDL, 0, 1);
      sw_a = '0;
      cyc(6);
      drain("wrong_step");

      // timeout
      pa(ENT, 1, 1);
      sw_a[0] = 1'b1;
      cyc(3);
      pa(FL, 0, 2);
      cyc(22);
      chk("timeout_not_early", qa.size(), 1);
      cyc(20);
      pa(IDL, 0, 2);
      sw_a = '0;
      cyc(6);
      drain("timeout");

      correct_entry(2);

      // fall during entry
      pa(ENT, 1, 0);
      sw_a[0] = 1'b1;
      cyc(5);
      pa(ENT, 2, 0);
      sw_a[1] = 1'b1;
      cyc(5);
      pa(FL, 0, 1);
      sw_a[1] = 1'b0;
      cyc(5);
      pa(IDL, 0, 1);
      sw_a = '0;
      cyc(6);
      drain("fall");

      // two rises at once
      pa(FL, 0, 2);
      sw_a = 10'b11;
      cyc(5);
      pa(IDL, 0, 2);
      sw_a = '0;
      cyc(6);
      drain("double_rise");

      correct_entry(2);

      // correct rise together with a fall
      pa(ENT, 1, 0);
      sw_a[0] = 1'b1;
      cyc(5);
      pa(FL, 0, 1);
      sw_a = 10'b10;
      cyc(5);
      pa(IDL, 0, 1);
      sw_a = '0;
      cyc(6);
      drain("rise_with_fall");

      // reset mid-entry, switches held through release
      pa(ENT, 1, 1);
      sw_a[0] = 1'b1;
      cyc(5);
      pa(ENT, 2, 1);
      sw_a[1] = 1'b1;
      cyc(5);
      pa(IDL, 0, 0);
      rst = 1'b0;
      cyc(2);
      chk("midrst_state", st_a, 1);
      chk("midrst_progress", pg_a, 0);
      chk("midrst_fail_cnt", fc_a, 0);
      cyc(8);
      rst = 1'b1;
      cyc(20);
      sw_a = '0;
      cyc(10);
      drain("mid_reset");
      correct_entry(0);

      // lockout with switches cleared promptly
      wrong_idle(1);
      wrong_idle(2);
      pa(FL, 0, 3);
      pa(LK, 0, 3);
      pa(IDL, 0, 0);
      sw_a[5] = 1'b1;
      cyc(3);
      sw_a = '0;
      cyc(30);
      drain("lockout_clear");
      chk("lock_dwell_exact", lk_dw, 21);

      // lockout with sw[0] held throughout
      wrong_idle(1);
      wrong_idle(2);
      pa(ENT, 1, 2);
      sw_a[0] = 1'b1;
      cyc(5);
      pa(FL, 0, 3);
      pa(LK, 0, 3);
      sw_a[2] = 1'b1;
      cyc(5);
      sw_a[2] = 1'b0;
      cyc(25);
      chk("alarm_held", al_a, 1);
      chk("lock_state_held", st_a, 16);
      pa(IDL, 0, 0);
      sw_a = '0;
      cyc(6);
      drain("lockout_hold");

      // 6-step code with repeated indices: re-raising needs a fall
      pb(ENT, 1, 0);
      sw_b[1] = 1'b1;
      cyc(5);
      pb(ENT, 2, 0);
      sw_b[0] = 1'b1;
      cyc(5);
      pb(ENT, 3, 0);
      sw_b[3] = 1'b1;
      cyc(5);
      pb(ENT, 4, 0);
      sw_b[2] = 1'b1;
      cyc(5);
      pb(FL, 0, 1);
      sw_b[1] = 1'b0;
      cyc(5);
      pb(IDL, 0, 1);
      sw_b = '0;
      cyc(6);
      drain("sweep");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mism);
      $finish;
   end

endmodule
